// File: rtl/reg_scoreboard_file.sv
// Architectural register file with per-register outstanding-write counters.
// Resolves reg_id_t operands (constants, rip, rimm, real regs) and stalls issue on pending writers.
module reg_scoreboard_file #(
  parameter int unsigned REG_FILE_SIZE = 20,
  parameter int unsigned PEND_W        = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [7:0]  src_a,
  input  logic [7:0]  src_b,
  input  logic [7:0]  dst,
  input  logic        dst_we,
  input  logic [63:0] rip_val,
  input  logic [63:0] imm_val,
  output logic [69:0] opa,
  output logic [69:0] opb,
  output logic        ops_valid,
  input  logic        wb_valid,
  input  logic [7:0]  wb_dst,
  input  logic [69:0] wb_val,
  input  logic        flush,
  output logic        bad_id
);

  localparam int unsigned IDX_W  = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
  localparam int unsigned VAL_W  = 70;
  localparam int unsigned FLAG_W = 6;

  // RegMap encoding: 0x00..0x04 are constant ids, bit 7 set marks a real register.
  localparam logic [7:0] ID_RV8  = 8'h02;
  localparam logic [7:0] ID_RIP  = 8'h03;
  localparam logic [7:0] ID_RIMM = 8'h04;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [6:0]        SIZE_7   = 7'(REG_FILE_SIZE);

  logic [VAL_W-1:0]  entries [REG_FILE_SIZE];
  logic [PEND_W-1:0] pending [REG_FILE_SIZE];

  logic                     a_busy;
  logic                     b_busy;
  logic                     dst_full;
  logic                     dst_mark;
  logic                     wb_real;
  logic                     accept;
  logic                     bad_next;
  logic [PEND_W-1:0]        dst_after;
  logic [VAL_W-1:0]         opa_next;
  logic [VAL_W-1:0]         opb_next;
  logic [REG_FILE_SIZE-1:0] inc_vec;
  logic [REG_FILE_SIZE-1:0] dec_vec;
  logic [REG_FILE_SIZE-1:0] wr_vec;

  function automatic logic id_real(input logic [7:0] id);
    return id[7] && (id[6:0] < SIZE_7);
  endfunction

  function automatic logic id_const(input logic [7:0] id);
    return id <= ID_RIMM;
  endfunction

  function automatic logic id_bad(input logic [7:0] id);
    return !id_real(id) && !id_const(id);
  endfunction

  function automatic logic [IDX_W-1:0] id_idx(input logic [7:0] id);
    return IDX_W'(id[6:0]);
  endfunction

  function automatic logic [PEND_W-1:0] pend_of(input logic [7:0] id);
    return id_real(id) ? pending[id_idx(id)] : '0;
  endfunction

  // A writeback retiring the last pending write makes the source ready this cycle.
  function automatic logic wb_bypass(input logic [7:0] id);
    return wb_valid && (wb_dst == id) && id_real(id) && (pend_of(id) == PEND_ONE);
  endfunction

  function automatic logic src_busy(input logic [7:0] id);
    return id_real(id) && (pend_of(id) != '0) && !wb_bypass(id);
  endfunction

  function automatic logic [VAL_W-1:0] resolve(input logic [7:0] id);
    if (id == ID_RV8)       return VAL_W'(8);
    else if (id == ID_RIP)  return {{FLAG_W{1'b0}}, rip_val};
    else if (id == ID_RIMM) return {{FLAG_W{1'b0}}, imm_val};
    else if (id_real(id))   return wb_bypass(id) ? wb_val : entries[id_idx(id)];
    else                    return '0;
  endfunction

  // Issue handshake, operand resolution and error detection.
  always_comb begin
    a_busy      = src_busy(src_a);
    b_busy      = src_busy(src_b);
    dst_after   = pend_of(dst) - PEND_W'(wb_valid && (wb_dst == dst) && (pend_of(dst) != '0));
    dst_full    = dst_we && id_real(dst) && (dst_after == PEND_MAX);
    issue_ready = !a_busy && !b_busy && !dst_full && !flush;
    accept      = issue_valid && issue_ready;
    dst_mark    = accept && dst_we && id_real(dst);
    wb_real     = wb_valid && id_real(wb_dst);
    opa_next    = resolve(src_a);
    opb_next    = resolve(src_b);
    bad_next    = (accept && (id_bad(src_a) || id_bad(src_b) || (dst_we && id_bad(dst))))
                || (wb_valid && !id_real(wb_dst));
  end

  // Per-register increment/decrement/write strobes.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    wr_vec  = '0;
    for (int unsigned i = 0; i < REG_FILE_SIZE; i++) begin
      inc_vec[i] = dst_mark && (id_idx(dst) == IDX_W'(i));
      wr_vec[i]  = wb_real && (id_idx(wb_dst) == IDX_W'(i));
      dec_vec[i] = wr_vec[i] && (pending[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa       <= '0;
      opb       <= '0;
      ops_valid <= 1'b0;
      bad_id    <= 1'b0;
      for (int unsigned i = 0; i < REG_FILE_SIZE; i++) begin
        entries[i] <= '0;
        pending[i] <= '0;
      end
    end else begin
      ops_valid <= accept;
      bad_id    <= bad_next;
      if (accept) begin
        opa <= opa_next;
        opb <= opb_next;
      end
      // Flush wins over same-cycle marks; writebacks still land in the array.
      for (int unsigned i = 0; i < REG_FILE_SIZE; i++) begin
        if (flush) pending[i] <= '0;
        else       pending[i] <= pending[i] + PEND_W'(inc_vec[i]) - PEND_W'(dec_vec[i]);
        if (wr_vec[i]) entries[i] <= wb_val;
      end
    end
  end

endmodule

// File: doc/reg_scoreboard_file.md
Name: reg_scoreboard_file

Overview:
- Architectural register file with a per-register write scoreboard, indexed by reg_id_t values from the RegMap package.
- Decode issues a uop naming up to two sources and one destination; the block stalls on pending writers, returns operand values one cycle after acceptance, and marks the destination busy.
- Writeback retires values and clears busy state.
- It is the consumer side of reg_id_t: it turns ids back into storage and constant operands.

Parameters:
- REG_FILE_SIZE, 20, number of real register entries; valid real ids are rax..rax+REG_FILE_SIZE-1.
- PEND_W, 2, width of the per-register outstanding-write counter; max pending = 2^PEND_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents a uop.
- issue_ready  out  1  combinational; uop accepted when issue_valid && issue_ready.
- src_a  in  8  reg_id_t of operand A.
- src_b  in  8  reg_id_t of operand B.
- dst  in  8  reg_id_t of destination.
- dst_we  in  1  uop writes dst.
- rip_val  in  64  value returned for rip.
- imm_val  in  64  value returned for rimm.
- opa  out  70  reg_val_t for src_a, registered.
- opb  out  70  reg_val_t for src_b, registered.
- ops_valid  out  1  one-cycle pulse; opa/opb valid.
- wb_valid  in  1  writeback strobe.
- wb_dst  in  8  reg_id_t written back.
- wb_val  in  70  reg_val_t written.
- flush  in  1  clear all pending counters; no array change.
- bad_id  out  1  registered one-cycle pulse on any illegal id use.

Behaviour:
- Reset (async, reset_n=0): all entries and counters 0; opa=opb=0; ops_valid=0; bad_id=0. Deassertion takes effect at the next clk edge.
- Operand resolution (flags and val):
  - rnil, rv0 -> all zero.
  - rv8 -> val=8, flags 0.
  - rip -> {flags 0, rip_val}.
  - rimm -> {flags 0, imm_val}.
  - Real id with index id[6:0] < REG_FILE_SIZE -> array entry.
  - Any other id -> zero, and bad_id pulses the next cycle if the uop is accepted.
- busy(id) = id is real and pending[id] != 0.
- Bypass: if wb_valid, wb_dst==src and pending[src]==1, the source is not busy and the operand takes wb_val in the same cycle.
- issue_ready = !busy(src_a) && !busy(src_b) && !(dst_we && dst real && pending[dst]==max after this cycle's wb decrement) && !flush.
- On accept:
  - opa/opb registered at the edge; ops_valid=1 for exactly one cycle. Latency is 1.
  - If dst_we and dst real, pending[dst] += 1.
  - dst_we to rnil/constant/rip/rimm: no marking, no error. Any other non-real dst: bad_id.
- Writeback on wb_valid:
  - Real wb_dst: the entry is written and pending[wb_dst] decrements, saturating at 0. Writeback at 0 pending still writes the entry.
  - Non-real wb_dst: ignored; bad_id pulses.
- Same edge, issue marks and wb clears the same register: the counter is unchanged net, and the entry takes wb_val.
- src==dst in one uop: the source is read with the old value; marking happens after the read.
- flush:
  - All pending counters go to 0 at the edge; flush has priority over same-cycle increments.
  - A concurrent wb still writes the array.
  - issue_ready=0 during flush.
- Idle: ops_valid=0; opa/opb hold their last values.

Test Plan:
- Reset then issue src_a=rv8, src_b=rimm, imm_val=0x55 -> next cycle ops_valid=1, opa.val=8, opb.val=0x55, flags 0.
- Issue dst=rax dst_we=1; then issue src_a=rax -> issue_ready=0. wb rax val=0x1234 with pending 1 in the same cycle -> accepted, opa.val=0x1234. Next cycle pending[rax]=0.
- Three issues to rcx, no wb -> pending=3. A fourth issue with dst=rcx -> issue_ready=0. One wb_valid -> ready=1 the same cycle.
- Issue src_a=8'h05 (unmapped fake) -> opa=0, bad_id=1 for one cycle. wb_dst=rip -> bad_id=1, no array change.
- Pending on rdx=2, assert flush -> issue_ready=0 that cycle. Next cycle, issue src_a=rdx -> accepted, returns the stored value.
- Pending rbx=1, assert reset_n=0 mid-operation -> opa, ops_valid and counters 0 immediately; after release, src_a=rbx reads 0 with no stall.
